pc_fetch_unit: RTL

Program-counter and fetch-sequencing stage directly upstream of the IF/ID pipeline register. It holds the fetch PC and drives it to the instruction cache. It generates PC+4 for the IF register and advances, holds or redirects the PC based on cache busy, the IF-stage jump freeze and resolved branch/jump redirects. Redirects that arrive while the cache is busy are buffered, and the wrong-path instruction is killed.

---
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and fetch sequencer feeding the IF/ID register. Holds the
//   fetch PC, drives it to the instruction cache and produces PC+4. The PC
//   advances, holds or redirects depending on cache busy, the IF-stage jump
//   freeze and resolved redirects. A redirect that arrives while the cache
//   is busy is parked until the access finishes. The wrong-path instruction
//   returned after any redirect is flagged for replacement with a bubble.
//
// Ports
//   clk              system clock, all state on posedge
//   rst              synchronous active-high reset
//   cache_done       1 = cache access in progress, 0 = inst for pc_out valid
//   jmp_freeze       1 = control transfer in flight, do not advance
//   redirect_valid   one-cycle pulse: load redirect_target
//   redirect_target  new fetch address (bits [1:0] forced to 0)
//   pc_out           current fetch address
//   PC_plus_4        pc_out + 4 (combinational, wraps modulo 2^32)
//   fetch_valid      returned instruction is on the correct path
//   inst_kill        returned instruction must be replaced by a bubble
//   hold_count       saturating count of consecutive non-advancing cycles
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_done,
  input  logic        jmp_freeze,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] PC_plus_4,
  output logic        fetch_valid,
  output logic        inst_kill,
  output logic [3:0]  hold_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_PEND  = 2'd3;

  localparam logic [3:0] HOLD_SAT = 4'(MAX_HOLD);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic [1:0]  state_reg, state_next;
  logic        kill_reg, kill_next;
  logic        first_reg;
  logic [3:0]  hold_count_reg;
  logic        hold_inc, hold_clr;
  logic [31:0] target_aligned;

  assign target_aligned = {redirect_target[31:2], 2'b00};

  // Next-state selection in priority order: redirect (direct or parked),
  // cache busy, release of a parked redirect, freeze, sequential advance.
  always_comb begin
    pc_next          = pc_reg;
    pend_target_next = pend_target_reg;
    state_next       = state_reg;
    kill_next        = kill_reg;
    hold_inc         = 1'b0;
    hold_clr         = 1'b0;
    if (redirect_valid && !cache_done) begin
      pc_next    = target_aligned;
      state_next = ST_RUN;
      kill_next  = 1'b1;
      hold_clr   = 1'b1;
    end else if (redirect_valid) begin
      // Newest redirect overwrites any target already parked.
      pend_target_next = target_aligned;
      state_next       = ST_PEND;
      kill_next        = 1'b1;
      hold_clr         = 1'b1;
    end else if (cache_done) begin
      state_next = (state_reg == ST_PEND) ? ST_PEND : ST_STALL;
      hold_inc   = 1'b1;
    end else if (state_reg == ST_PEND) begin
      // Access finished: the returning instruction is wrong-path (killed
      // this cycle), and fetch continues at the parked target.
      pc_next    = pend_target_reg;
      state_next = ST_RUN;
      kill_next  = 1'b0;
      hold_clr   = 1'b1;
    end else if (jmp_freeze) begin
      state_next = ST_HOLD;
      kill_next  = 1'b0;
      hold_inc   = 1'b1;
    end else begin
      pc_next    = pc_reg + 32'd4;
      state_next = ST_RUN;
      kill_next  = 1'b0;
      hold_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      pend_target_reg <= 32'h0;
      state_reg       <= ST_RUN;
      kill_reg        <= 1'b0;
      first_reg       <= 1'b1;
      hold_count_reg  <= 4'd0;
    end else begin
      pc_reg          <= pc_next;
      pend_target_reg <= pend_target_next;
      state_reg       <= state_next;
      kill_reg        <= kill_next;
      first_reg       <= 1'b0;
      if (hold_clr) begin
        hold_count_reg <= 4'd0;
      end else if (hold_inc && (hold_count_reg != HOLD_SAT)) begin
        hold_count_reg <= hold_count_reg + 4'd1;
      end
    end
  end

  assign pc_out     = pc_reg;
  assign PC_plus_4  = pc_reg + 32'd4;
  assign hold_count = hold_count_reg;
  assign inst_kill  = kill_reg & ~cache_done;
  // In HOLD the instruction at the held PC was already delivered on the
  // first frozen cycle, so repeats are not valid. PEND always has kill set.
  assign fetch_valid = ~first_reg & ~cache_done & ~kill_reg &
                       ((state_reg == ST_RUN) || (state_reg == ST_STALL));

endmodule
